// File: rtl/divisor_shift_sub.sv
// divisor_shift_sub: sequential 8-bit by 4-bit unsigned restoring divider.
// A start pulse latches the operands. One CHECK cycle screens for quotient
// overflow, then four DIV cycles retire one quotient bit each. X holds
// {remainder, quotient} once finished, and Done pulses for one cycle.
module divisor_shift_sub (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       St,
    input  logic [7:0] Dividendo,
    input  logic [3:0] Divisor,
    output logic [3:0] Quociente,
    output logic [3:0] Resto,
    output logic       V,
    output logic       Done,
    output logic       Idle
);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StDiv,
        StDone
    } state_e;

    state_e      state_q;
    logic [8:0]  x_q;
    logic [3:0]  y_q;
    logic [1:0]  cnt_q;
    logic        v_q;

    // One restoring iteration: shift left, then try to subtract the divisor
    // from the upper five bits. The LSB of the result is the new quotient bit.
    logic [8:0]  shift_x;
    logic [4:0]  shift_hi;
    logic [4:0]  y_ext;
    logic [4:0]  diff;
    logic        fits;
    logic [8:0]  x_step;
    logic        overflow;

    // Datapath for a single shift-subtract step and the overflow screen.
    always_comb begin
        shift_x  = {x_q[7:0], 1'b0};
        shift_hi = shift_x[8:4];
        y_ext    = {1'b0, y_q};
        fits     = (shift_hi >= y_ext);
        diff     = shift_hi - y_ext;
        x_step   = fits ? {diff, shift_x[3:1], 1'b1} : shift_x;
        // Dividend >= 16*divisor means the quotient does not fit in 4 bits;
        // a zero divisor always lands here too.
        overflow = (x_q[7:4] >= y_q);
    end

    // X[8] only carries a shifted-out bit inside the step and always ends at 0.
    logic unused_x_msb;
    assign unused_x_msb = x_q[8];

    // Control FSM and working registers, all updated together.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            x_q     <= 9'd0;
            y_q     <= 4'd0;
            cnt_q   <= 2'd0;
            v_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (St) begin
                        x_q     <= {1'b0, Dividendo};
                        y_q     <= Divisor;
                        v_q     <= 1'b0;
                        cnt_q   <= 2'd0;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (overflow) begin
                        x_q     <= 9'd0;
                        v_q     <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StDiv;
                    end
                end
                StDiv: begin
                    x_q   <= x_step;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs are views of the registered state.
    always_comb begin
        Quociente = x_q[3:0];
        Resto     = x_q[7:4];
        V         = v_q;
        Done      = (state_q == StDone);
        Idle      = (state_q == StIdle);
    end

endmodule

// File: tb/tb_divisor_shift_sub.sv
// Scoreboard bench for divisor_shift_sub: stimulus pushes expected results
// computed with plain integer division; a monitor pops on every Done.
module tb_divisor_shift_sub;

    logic       Clk;
    logic       Rst;
    logic       St;
    logic [7:0] Dividendo;
    logic [3:0] Divisor;
    logic [3:0] Quociente;
    logic [3:0] Resto;
    logic       V;
    logic       Done;
    logic       Idle;

    divisor_shift_sub dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .St        (St),
        .Dividendo (Dividendo),
        .Divisor   (Divisor),
        .Quociente (Quociente),
        .Resto     (Resto),
        .V         (V),
        .Done      (Done),
        .Idle      (Idle)
    );

    typedef struct {
        int q;
        int r;
        int v;
        int c0;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   run = 0;
    int   last_q = 0;
    int   last_r = 0;
    int   last_v = 0;
    bit   last_valid = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc = cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: ordinary integer division, overflow when the quotient needs >4 bits.
    function automatic exp_t model(int a, int b, int c0);
        exp_t e;
        e.c0 = c0;
        if (b == 0 || a / b > 15) begin
            e.q = 0;
            e.r = 0;
            e.v = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.v = 0;
        end
        return e;
    endfunction

    // Monitor: result on Done, latency, Idle-low length, and stability while idle.
    always @(negedge Clk) begin
        if (Rst) begin
            run = 0;
            last_valid = 0;
        end else begin
            if (Done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quociente", int'(Quociente), e.q);
                    chk("resto", int'(Resto), e.r);
                    chk("v", int'(V), e.v);
                    chk("done_latency", cyc - e.c0, (e.v != 0) ? 1 : 5);
                    last_q = e.q;
                    last_r = e.r;
                    last_v = e.v;
                    last_valid = 1;
                end
            end
            if (!Idle) begin
                run++;
            end else begin
                if (run > 0 && last_valid) begin
                    chk("idle_low_cycles", run, (last_v != 0) ? 2 : 6);
                end
                run = 0;
                if (last_valid) begin
                    chk("hold_q", int'(Quociente), last_q);
                    chk("hold_r", int'(Resto), last_r);
                    chk("hold_v", int'(V), last_v);
                end
            end
        end
    end

    // Issue one start pulse; returns 2 time units after the start edge.
    task automatic start(input int a, input int b);
        @(posedge Clk);
        #2;
        St = 1'b1;
        Dividendo = 8'(a);
        Divisor = 4'(b);
        @(posedge Clk);
        #2;
        St = 1'b0;
        sb.push_back(model(a, b, cyc));
    endtask

    // Wait, bounded, until every issued job has reported.
    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic job(input int a, input int b);
        start(a, b);
        wait_done();
    endtask

    initial begin
        Rst = 1'b1;
        St = 1'b0;
        Dividendo = 8'd0;
        Divisor = 4'd0;
        #3;
        chk("rst_q", int'(Quociente), 0);
        chk("rst_r", int'(Resto), 0);
        chk("rst_v", int'(V), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_idle", int'(Idle), 1);
        @(posedge Clk);
        #2;
        Rst = 1'b0;

        // Directed cases.
        job(135, 13);
        job(239, 15);
        job(0, 5);
        job(255, 15);
        job(100, 0);

        // Start and operand changes during DIV are ignored.
        start(135, 13);
        @(posedge Clk);
        @(posedge Clk);
        #2;
        St = 1'b1;
        Dividendo = 8'd50;
        Divisor = 4'd7;
        @(posedge Clk);
        #2;
        St = 1'b0;
        wait_done();
        repeat (3) @(negedge Clk);
        chk("busy_no_extra_job", int'(Idle), 1);
        job(50, 7);

        // Asynchronous reset in the second DIV cycle aborts the job.
        start(135, 13);
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        chk("midrst_q", int'(Quociente), 0);
        chk("midrst_r", int'(Resto), 0);
        chk("midrst_v", int'(V), 0);
        chk("midrst_done", int'(Done), 0);
        chk("midrst_idle", int'(Idle), 1);
        sb.delete();
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        job(200, 9);
        job(143, 9);

        // Randomized jobs with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            int gap;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(posedge Clk);
            job(a, b);
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
